// File: rtl/btn_pkg.sv
// Shared definitions for the button-conditioning path (debouncer and
// event generator): state encoding, default 25 MHz timing, width helpers.
package btn_pkg;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        IDLE         = 2'd1,
        PRESSED      = 2'd2,
        REPEATING    = 2'd3
    } btn_state_e;

    // 1 s hold before long-press, 200 ms auto-repeat period, at 25 MHz
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 25_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES     = 5_000_000;

    // Bits needed to hold values 0 .. value-1; never less than 1.
    function automatic int clog2(input longint unsigned value);
        int w;
        w = 0;
        while ((64'd1 << w) < value) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic longint unsigned max_u(input longint unsigned a,
                                              input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_gen.sv
// Turns the debounced button level into single-cycle UI events
// (press, release, long-press, auto-repeat) plus a held level.
// Every output is registered; a button held through reset or through an
// enable drop must be released before a new press is accepted.
module btn_event_gen
    import btn_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int CNT_W = clog2(max_u(64'(LONG_PRESS_CYCLES), 64'(REPEAT_CYCLES)));

    // Last counter value of each phase; the threshold edge is the one that sees it
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  =
        (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);
    localparam bit REP_EN = (REPEAT_CYCLES != 0);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;

    // Next-state, counter and output decode; release beats any threshold
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        held_d  = 1'b0;

        if (!enable) begin
            state_d = WAIT_RELEASE;
        end else begin
            case (state_q)
                WAIT_RELEASE: begin
                    if (!btn_level) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (btn_level) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        held_d  = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_level) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                    end else begin
                        held_d = 1'b1;
                        if (cnt_q == LONG_LAST) begin
                            long_d  = 1'b1;
                            state_d = REPEATING;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                REPEATING: begin
                    if (!btn_level) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                    end else begin
                        held_d = 1'b1;
                        if (!REP_EN) begin
                            cnt_d = '0;
                        end else if (cnt_q == REP_LAST) begin
                            rep_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = WAIT_RELEASE;
                end
            endcase
        end
    end

    // State, counter and registered outputs; reset parks in WAIT_RELEASE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = rep_q;
    assign held          = held_q;

endmodule
